// File: rtl/po_capture_pkg.sv
// ---------------------------------------------------------------------------
// po_capture_pkg
// Shared definitions for the primary-output capture stage: FSM state
// encoding, entry layout, widths and the MISR next-state function.
// ---------------------------------------------------------------------------
package po_capture_pkg;

  localparam int TAG_W   = 8;
  localparam int PO_W    = 8;
  localparam int ENTRY_W = TAG_W + PO_W;

  // CCITT polynomial x^16 + x^12 + x^5 + 1 (x^16 term implied)
  localparam logic [15:0] MISR_POLY = 16'h1021;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  // Packed so that tag lands in the upper byte of the 16-bit FIFO word
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PO_W-1:0]  po;
  } entry_t;

  // One MISR step: shift left, fold the feedback polynomial in when the
  // bit shifted out was set, then inject the sampled outputs in the low byte.
  function automatic logic [15:0] misr_next(input logic [15:0]     sig,
                                            input logic [PO_W-1:0] po);
    logic [15:0] w_fb;
    w_fb      = sig[15] ? MISR_POLY : 16'h0000;
    misr_next = {sig[14:0], 1'b0} ^ w_fb ^ {{(16-PO_W){1'b0}}, po};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage. The head entry is read straight
// out of the storage register, so o_data only changes on a pop or when the
// first entry lands in an empty FIFO.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (empties FIFO, clears storage)
//   i_push   in   write i_data (accepted if not full, or full with a pop)
//   i_pop    in   remove the head entry (ignored when empty)
//   i_data   in   WIDTH-bit entry to write
//   o_data   out  head entry
//   o_full   out  DEPTH entries held
//   o_empty  out  no entries held
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit; equal index with differing wrap bit
  // means full, identical pointers mean empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (w_wr_idx == w_rd_idx);

  // When full, a simultaneous pop frees the slot being written: the write
  // lands in the old head's slot while the head moves to the next entry.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_data = r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[w_wr_idx] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/po_capture_stage.sv
// ---------------------------------------------------------------------------
// po_capture_stage
// Captures the primary-output vector of a combinational netlist a fixed
// number of cycles after each stimulus launch, tags each sample, queues it
// for a valid/ready consumer and folds it into a 16-bit MISR signature.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   launch     in   pulse: netlist inputs changed this cycle
//   po_in      in   8-bit netlist outputs
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts the head
//   out_data   out  {tag, po} of the head entry
//   busy       out  waiting for the netlist to settle
//   overflow   out  sticky: a sample was dropped on a full FIFO
//   sig_clear  in   synchronous clear of signature, tag and overflow
//   signature  out  current MISR value
// ---------------------------------------------------------------------------
module po_capture_stage
  import po_capture_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        launch,
  input  logic [7:0]  po_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        overflow,
  input  logic        sig_clear,
  output logic [15:0] signature
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [15:0]      r_sig;
  logic             r_ovf;

  logic   w_sample;
  logic   w_pop;
  logic   w_drop;
  logic   w_full;
  logic   w_empty;
  entry_t w_entry;

  // A launch always wins over the sample edge: the netlist inputs just
  // changed again, so the outputs are not yet trustworthy.
  assign w_sample = (r_state == ST_SETTLE) && !launch && (r_cnt == 4'd0);

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_drop    = w_sample && w_full && !w_pop;

  assign w_entry.tag = r_tag;
  assign w_entry.po  = po_in;

  assign busy      = (r_state == ST_SETTLE);
  assign overflow  = r_ovf;
  assign signature = r_sig;

  // --- settle FSM: launch -> count down -> sample ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      if (launch) begin
        r_state <= ST_SETTLE;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_SETTLE) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  // --- sample bookkeeping: tag, signature, overflow ---
  // Tag and signature advance on every sample, even when the FIFO drops it,
  // so the signature reflects the full response stream. sig_clear takes
  // priority over a coincident sample (the entry itself is still pushed
  // with the pre-clear tag through w_entry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
      r_sig <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (sig_clear) begin
      r_tag <= '0;
      r_sig <= 16'h0000;
      r_ovf <= 1'b0;
    end else begin
      if (w_sample) begin
        r_tag <= r_tag + 8'd1;
        r_sig <= misr_next(r_sig, po_in);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // --- output queue ---
  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_sample),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
